// File: rtl/bcrypt_cmp_config_tx_pkg.sv
// bcrypt_cmp_config_tx_pkg: shared constants, FSM states and subtype check for the CMP_CONFIG serializer
package bcrypt_cmp_config_tx_pkg;
    localparam int DEF_NUM_HASHES = 512;
    localparam int DEF_HASH_NUM_MSB = 8;
    localparam int DEF_HASH_COUNT_MSB = 9;
    localparam logic [7:0] CMP_CONFIG_MAGIC = 8'hCC;
    localparam logic [7:0] SUBTYPE_A = 8'h61;
    localparam logic [7:0] SUBTYPE_B = 8'h62;
    localparam logic [7:0] SUBTYPE_X = 8'h78;
    localparam logic [7:0] SUBTYPE_Y = 8'h79;
    typedef enum logic [3:0] {IDLE, SALT, SUBTYPE, ITER, COUNT0, COUNT1, FETCH, CMP_DATA, MAGIC} state_t;
    function automatic logic subtype_ok(input logic [7:0] s);
        return s == SUBTYPE_A || s == SUBTYPE_B || s == SUBTYPE_X || s == SUBTYPE_Y;
    endfunction
endpackage

// File: rtl/bcrypt_cmp_config_tx_if.sv
// bcrypt_cmp_config_tx_if: byte stream with wr_en strobe and consumer back-pressure
interface bcrypt_cmp_config_tx_if;
    import bcrypt_cmp_config_tx_pkg::*;
    logic [7:0] dout;
    logic wr_en;
    logic full;
    modport master(output dout, wr_en, input full);
    modport slave(input dout, wr_en, output full);
endinterface

// File: rtl/bcrypt_cmp_config_tx_hashfetch.sv
// bcrypt_cmp_config_tx_hashfetch: hash RAM address counter, read strobe and word capture register
module bcrypt_cmp_config_tx_hashfetch
    import bcrypt_cmp_config_tx_pkg::*;
#(
    parameter int HASH_NUM_MSB = DEF_HASH_NUM_MSB,
    parameter int HASH_COUNT_MSB = DEF_HASH_COUNT_MSB
) (
    input  logic                  CLK,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  word_req,
    input  logic [HASH_COUNT_MSB:0] cnt,
    output logic                  hash_rd_en,
    output logic [HASH_NUM_MSB:0] hash_rd_addr,
    input  logic [30:0]           hash_rd_data,
    output logic                  word_ready,
    output logic                  last,
    output logic [31:0]           word
);
    localparam int CW = HASH_COUNT_MSB + 1;
    localparam int AW = HASH_NUM_MSB + 1;
    logic at_end;
    assign hash_rd_en = word_req;
    assign at_end = CW'(hash_rd_addr) == cnt - CW'(1);
    // Address stops on the final entry so it never wraps; last marks the word just fetched.
    always_ff @(posedge CLK) begin
        if (rst || clear) begin
            hash_rd_addr <= '0;
            word_ready <= 1'b0;
            last <= 1'b0;
            word <= '0;
        end else begin
            word_ready <= word_req;
            if (word_req) begin
                last <= at_end;
                if (!at_end) hash_rd_addr <= hash_rd_addr + AW'(1);
            end
            if (word_ready) word <= {1'b0, hash_rd_data};
        end
    end
endmodule

// File: rtl/bcrypt_cmp_config_tx.sv
// bcrypt_cmp_config_tx: serializes a bcrypt CMP_CONFIG packet onto a wr_en/full byte stream
module bcrypt_cmp_config_tx
    import bcrypt_cmp_config_tx_pkg::*;
#(
    parameter int NUM_HASHES = DEF_NUM_HASHES,
    parameter int HASH_NUM_MSB = DEF_HASH_NUM_MSB,
    parameter int HASH_COUNT_MSB = DEF_HASH_COUNT_MSB
) (
    input  logic                    CLK,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    mode_cmp,
    input  logic [127:0]            cfg_salt,
    input  logic [7:0]              cfg_subtype,
    input  logic [31:0]             cfg_iter_count,
    input  logic [HASH_COUNT_MSB:0] cfg_hash_count,
    output logic                    hash_rd_en,
    output logic [HASH_NUM_MSB:0]   hash_rd_addr,
    input  logic [30:0]             hash_rd_data,
    bcrypt_cmp_config_tx_if.master  tx,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);
    localparam int CW = HASH_COUNT_MSB + 1;
    state_t state, state_nxt;
    logic [1:0] byte_cnt, byte_nxt, word_cnt, word_nxt, byte_inc;
    logic [3:0] salt_idx;
    logic bv, bv_nxt, busy_nxt, done_nxt, error_nxt, accept, req, xfer, cfg_ok;
    logic [7:0] dout_r, dout_nxt, sub_r;
    logic [127:0] salt_r;
    logic [31:0] iter_r, word;
    logic [CW-1:0] cnt_r;
    logic [15:0] cnt16;
    logic word_ready, last;
    assign xfer = bv & ~tx.full;
    assign tx.wr_en = xfer;
    assign tx.dout = dout_r;
    assign cnt16 = 16'(cnt_r);
    assign salt_idx = {word_cnt, byte_cnt} + 4'd1;
    assign byte_inc = byte_cnt + 2'd1;
    assign cfg_ok = subtype_ok(cfg_subtype) &&
                    (!mode_cmp || (cfg_hash_count != '0 && cfg_hash_count <= CW'(NUM_HASHES)));
    bcrypt_cmp_config_tx_hashfetch #(
        .HASH_NUM_MSB(HASH_NUM_MSB),
        .HASH_COUNT_MSB(HASH_COUNT_MSB)
    ) u_fetch (
        .CLK(CLK),
        .rst(rst),
        .clear(accept),
        .word_req(req),
        .cnt(cnt_r),
        .hash_rd_en(hash_rd_en),
        .hash_rd_addr(hash_rd_addr),
        .hash_rd_data(hash_rd_data),
        .word_ready(word_ready),
        .last(last),
        .word(word)
    );
    // The state names the byte held in dout; on each transfer the next byte is loaded.
    always_comb begin
        state_nxt = state;
        byte_nxt = byte_cnt;
        word_nxt = word_cnt;
        bv_nxt = bv;
        dout_nxt = dout_r;
        busy_nxt = busy;
        done_nxt = 1'b0;
        error_nxt = 1'b0;
        accept = 1'b0;
        req = 1'b0;
        case (state)
            IDLE: if (start) begin
                accept = cfg_ok;
                error_nxt = ~cfg_ok;
                state_nxt = cfg_ok ? SALT : IDLE;
                byte_nxt = 2'd0;
                word_nxt = 2'd0;
                bv_nxt = cfg_ok;
                busy_nxt = cfg_ok;
                dout_nxt = cfg_ok ? cfg_salt[7:0] : dout_r;
            end
            SALT: if (xfer) begin
                {word_nxt, byte_nxt} = salt_idx;
                state_nxt = (salt_idx == 4'd0) ? SUBTYPE : SALT;
                dout_nxt = (salt_idx == 4'd0) ? sub_r : salt_r[8*salt_idx +: 8];
            end
            SUBTYPE: if (xfer) begin
                state_nxt = ITER;
                byte_nxt = 2'd0;
                dout_nxt = iter_r[7:0];
            end
            ITER: if (xfer) begin
                byte_nxt = byte_inc;
                state_nxt = (byte_cnt == 2'd3) ? COUNT0 : ITER;
                dout_nxt = (byte_cnt == 2'd3) ? cnt16[7:0] : iter_r[8*byte_inc +: 8];
            end
            COUNT0: if (xfer) begin
                state_nxt = COUNT1;
                dout_nxt = cnt16[15:8];
            end
            COUNT1: if (xfer) begin
                state_nxt = (cnt_r != '0) ? FETCH : MAGIC;
                bv_nxt = (cnt_r == '0);
                dout_nxt = CMP_CONFIG_MAGIC;
            end
            FETCH: begin
                req = ~word_ready;
                if (word_ready) begin
                    state_nxt = CMP_DATA;
                    byte_nxt = 2'd0;
                    bv_nxt = 1'b1;
                    dout_nxt = hash_rd_data[7:0];
                end
            end
            CMP_DATA: if (xfer) begin
                byte_nxt = byte_inc;
                state_nxt = (byte_cnt != 2'd3) ? CMP_DATA : (last ? MAGIC : FETCH);
                bv_nxt = (byte_cnt != 2'd3) || last;
                dout_nxt = (byte_cnt != 2'd3) ? word[8*byte_inc +: 8] : CMP_CONFIG_MAGIC;
            end
            MAGIC: if (xfer) begin
                state_nxt = IDLE;
                bv_nxt = 1'b0;
                busy_nxt = 1'b0;
                done_nxt = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end
    // Control and output registers; reset aborts any packet in flight.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state <= IDLE;
            byte_cnt <= 2'd0;
            word_cnt <= 2'd0;
            bv <= 1'b0;
            dout_r <= 8'd0;
            busy <= 1'b0;
            done <= 1'b0;
            error <= 1'b0;
        end else begin
            state <= state_nxt;
            byte_cnt <= byte_nxt;
            word_cnt <= word_nxt;
            bv <= bv_nxt;
            dout_r <= dout_nxt;
            busy <= busy_nxt;
            done <= done_nxt;
            error <= error_nxt;
        end
    end
    // Configuration snapshot taken when a start is accepted; count is zero outside compare mode.
    always_ff @(posedge CLK) begin
        if (accept) begin
            salt_r <= cfg_salt;
            sub_r <= cfg_subtype;
            iter_r <= cfg_iter_count;
            cnt_r <= mode_cmp ? cfg_hash_count : '0;
        end
    end
endmodule

// File: tb/tb_bcrypt_cmp_config_tx.sv
// tb_bcrypt_cmp_config_tx: scoreboard bench for the CMP_CONFIG serializer
module tb_bcrypt_cmp_config_tx;
    logic CLK, rst, start, mode_cmp;
    logic [127:0] cfg_salt;
    logic [7:0] cfg_subtype;
    logic [31:0] cfg_iter_count;
    logic [9:0] cfg_hash_count;
    logic hash_rd_en;
    logic [8:0] hash_rd_addr;
    logic [30:0] hash_rd_data;
    logic busy, done, error;
    logic [30:0] ram [512];
    logic [7:0] exp_q [$];
    int vectors = 0, miscompares = 0;
    int byte_total = 0, rd_total = 0, done_cnt = 0, err_cnt = 0, last_addr = 0;
    int byte_base = 0, rd_base = 0;
    logic [7:0] t1 [32] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                           8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F,
                           8'h62, 8'h20, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00,
                           8'h78, 8'h56, 8'h34, 8'h12, 8'hFF, 8'hFF, 8'hFF, 8'h7F, 8'hCC};
    localparam logic [127:0] SALT1 = 128'h0F0E0D0C0B0A09080706050403020100;
    bcrypt_cmp_config_tx_if tx();
    bcrypt_cmp_config_tx dut (
        .CLK(CLK), .rst(rst), .start(start), .mode_cmp(mode_cmp),
        .cfg_salt(cfg_salt), .cfg_subtype(cfg_subtype), .cfg_iter_count(cfg_iter_count),
        .cfg_hash_count(cfg_hash_count), .hash_rd_en(hash_rd_en), .hash_rd_addr(hash_rd_addr),
        .hash_rd_data(hash_rd_data), .tx(tx), .busy(busy), .done(done), .error(error)
    );
    initial CLK = 0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) if (hash_rd_en) hash_rd_data <= ram[hash_rd_addr];
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask
    always @(negedge CLK) begin
        if (tx.wr_en) begin
            byte_total++;
            check("wr_en_while_full", 32'(tx.full), 0);
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL extra_byte: got %h, expected no byte", tx.dout);
            end else check("byte", 32'(tx.dout), 32'(exp_q.pop_front()));
        end
        if (hash_rd_en) begin
            check("rd_addr", 32'(hash_rd_addr), rd_total - rd_base);
            rd_total++;
            last_addr = int'(hash_rd_addr);
        end
        if (done) done_cnt++;
        if (error) err_cnt++;
    end
    task automatic push_t1();
        foreach (t1[i]) exp_q.push_back(t1[i]);
    endtask
    task automatic push_pkt(input logic [127:0] s, input logic [7:0] st, input logic [31:0] it, input int n);
        logic [31:0] v;
        for (int i = 0; i < 16; i++) exp_q.push_back(s[8*i +: 8]);
        exp_q.push_back(st);
        for (int i = 0; i < 4; i++) exp_q.push_back(it[8*i +: 8]);
        exp_q.push_back(n[7:0]);
        exp_q.push_back(n[15:8]);
        for (int h = 0; h < n; h++) begin
            v = {1'b0, ram[h]};
            for (int i = 0; i < 4; i++) exp_q.push_back(v[8*i +: 8]);
        end
        exp_q.push_back(8'hCC);
    endtask
    task automatic start_pkt(input logic m, input logic [127:0] s, input logic [7:0] st,
                             input logic [31:0] it, input logic [9:0] n);
        mode_cmp = m; cfg_salt = s; cfg_subtype = st; cfg_iter_count = it; cfg_hash_count = n;
        byte_base = byte_total;
        rd_base = rd_total;
        start = 1;
        @(posedge CLK); #1;
        start = 0;
    endtask
    task automatic wait_done(input string name, input int budget, input int d0);
        int c = 0;
        while (done_cnt == d0 && c < budget) begin
            @(posedge CLK); #1;
            c++;
        end
        check({name, "_done_seen"}, done_cnt - d0, 1);
        repeat (3) @(posedge CLK);
        #1;
        check({name, "_done_once"}, done_cnt - d0, 1);
        check({name, "_queue_empty"}, exp_q.size(), 0);
        check({name, "_busy_after"}, 32'(busy), 0);
    endtask
    task automatic reject(input string name, input logic m, input logic [7:0] st, input logic [9:0] n);
        int e0 = err_cnt;
        start_pkt(m, SALT1, st, 32'h20, n);
        repeat (3) @(posedge CLK);
        #1;
        check({name, "_error"}, err_cnt - e0, 1);
        check({name, "_busy"}, 32'(busy), 0);
        check({name, "_bytes"}, byte_total - byte_base, 0);
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
    initial begin
        int d0, e0, c, held;
        logic [7:0] hold_val;
        rst = 1; start = 0; mode_cmp = 0; cfg_salt = '0; cfg_subtype = 0;
        cfg_iter_count = 0; cfg_hash_count = 0; tx.full = 0;
        ram[0] = 31'h12345678;
        ram[1] = 31'h7FFFFFFF;
        repeat (3) @(posedge CLK);
        #1;
        rst = 0;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_error", 32'(error), 0);
        check("rst_wr_en", 32'(tx.wr_en), 0);
        check("rst_rd_en", 32'(hash_rd_en), 0);
        check("rst_rd_addr", 32'(hash_rd_addr), 0);
        check("rst_dout", 32'(tx.dout), 0);
        // compare mode, two hashes, no back-pressure
        push_t1();
        d0 = done_cnt;
        start_pkt(1, SALT1, 8'h62, 32'h20, 10'd2);
        check("t1_first_byte_valid", 32'(tx.wr_en), 1);
        check("t1_busy", 32'(busy), 1);
        wait_done("t1", 200, d0);
        check("t1_len", byte_total - byte_base, 32);
        check("t1_reads", rd_total - rd_base, 2);
        // no-compare mode ignores hash count
        push_pkt(128'hA5A4A3A2A1A0_9F9E9D9C9B9A_99989796, 8'h79, 32'hDEADBEEF, 0);
        d0 = done_cnt;
        start_pkt(0, 128'hA5A4A3A2A1A0_9F9E9D9C9B9A_99989796, 8'h79, 32'hDEADBEEF, 10'd5);
        wait_done("t2", 200, d0);
        check("t2_len", byte_total - byte_base, 24);
        check("t2_reads", rd_total - rd_base, 0);
        // back-pressure: toggling full plus a 20-cycle hold in ITER
        push_t1();
        d0 = done_cnt;
        start_pkt(1, SALT1, 8'h62, 32'h20, 10'd2);
        held = 0;
        c = 0;
        while (done_cnt == d0 && c < 400) begin
            if (held == 0 && byte_total - byte_base == 18) begin
                held = 1;
                tx.full = 1;
                @(negedge CLK);
                hold_val = tx.dout;
                for (int k = 0; k < 20; k++) begin
                    @(negedge CLK);
                    check("hold_dout", 32'(tx.dout), 32'(hold_val));
                    check("hold_wr_en", 32'(tx.wr_en), 0);
                end
                @(posedge CLK); #1;
                tx.full = 0;
            end else begin
                @(posedge CLK); #1;
                tx.full = ~tx.full;
            end
            c++;
        end
        tx.full = 0;
        check("t3_hold_seen", held, 1);
        wait_done("t3", 50, d0);
        check("t3_len", byte_total - byte_base, 32);
        // rejected starts
        reject("bad_subtype", 1, 8'h63, 10'd2);
        reject("zero_count", 1, 8'h61, 10'd0);
        reject("over_count", 1, 8'h78, 10'd513);
        // start while busy is ignored
        push_t1();
        d0 = done_cnt;
        e0 = err_cnt;
        start_pkt(1, SALT1, 8'h62, 32'h20, 10'd2);
        repeat (5) @(posedge CLK);
        #1;
        mode_cmp = 0; cfg_salt = '1; cfg_subtype = 8'h63; cfg_hash_count = 10'd0;
        start = 1;
        @(posedge CLK); #1;
        start = 0;
        wait_done("t7", 200, d0);
        check("t7_no_error", err_cnt - e0, 0);
        check("t7_len", byte_total - byte_base, 32);
        // reset during the second hash word, then a clean packet
        push_t1();
        d0 = done_cnt;
        start_pkt(1, SALT1, 8'h62, 32'h20, 10'd2);
        c = 0;
        while (byte_total - byte_base != 28 && c < 200) begin
            @(posedge CLK); #1;
            c++;
        end
        check("t6_reached_word1", byte_total - byte_base, 28);
        rst = 1;
        @(posedge CLK); #1;
        rst = 0;
        exp_q.delete();
        check("t6_wr_en_after_rst", 32'(tx.wr_en), 0);
        check("t6_busy_after_rst", 32'(busy), 0);
        repeat (5) @(posedge CLK);
        #1;
        check("t6_no_done", done_cnt - d0, 0);
        push_t1();
        d0 = done_cnt;
        start_pkt(1, SALT1, 8'h62, 32'h20, 10'd2);
        wait_done("t6b", 200, d0);
        check("t6b_len", byte_total - byte_base, 32);
        check("t6b_reads", rd_total - rd_base, 2);
        // maximum hash count
        for (int i = 0; i < 512; i++) ram[i] = 31'(i * 32'h00010203 + 32'h7F001357);
        push_pkt(SALT1, 8'h61, 32'h0000_1000, 512);
        d0 = done_cnt;
        start_pkt(1, SALT1, 8'h61, 32'h0000_1000, 10'd512);
        wait_done("t8", 5000, d0);
        check("t8_len", byte_total - byte_base, 2072);
        check("t8_reads", rd_total - rd_base, 512);
        check("t8_last_addr", last_addr, 511);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
